lvds_tx_serializer: RTL and testbench

LVDS_TX_SERIALIZER -- requirements
Module: lvds_tx_serializer

---
 rtl/lvds_tx_serializer.sv | 137 +++++++++++++
 tb/tb_lvds_tx_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_serializer.sv
// lvds_tx_serializer: 10-bit word to serial bit stream for an LVDS output buffer.
// Words go out LSB ('a') first, back to back, one bit per clock. After reset,
// SYNC_WORDS idle words are sent before user data is allowed onto the line.
// Optional macro SER_COMMA_IDLE_EN: when defined, the idle word is K28.5 with
// alternating running disparity (10'h17C / 10'h283); when undefined, the idle
// word is the constant 10'h2AA (a 0,1,0,1,... pattern).
module lvds_tx_serializer #(
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] datain,
    input  logic       datain_valid,
    output logic       datain_ready,
    output logic       serout,
    output logic       frame_start,
    output logic       idle_tx
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [9:0] IDLE_K28_5_RDN = 10'h17C;
    localparam logic [9:0] IDLE_K28_5_RDP = 10'h283;
    localparam logic [9:0] IDLE_ALT       = 10'h2AA;
    localparam logic [3:0] SYNC_LAST      = 4'(SYNC_WORDS - 1);

    state_t     state_q, state_d;
    logic [9:0] shreg_q, shreg_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [9:0] buf_q, buf_d;
    logic       bufFull_q, bufFull_d;
    logic [3:0] syncCnt_q, syncCnt_d;
    logic       idleTx_q, idleTx_d;
    logic       frameStart_q, frameStart_d;
    logic [9:0] idleWord;
    logic       loadEdge;
    logic       xfer;

`ifdef SER_COMMA_IDLE_EN
    logic toggle_q, toggle_d;
    assign idleWord = toggle_q ? IDLE_K28_5_RDP : IDLE_K28_5_RDN;
`else
    assign idleWord = IDLE_ALT;
`endif

    assign loadEdge     = (bitcnt_q == 4'd9);
    assign xfer         = datain_valid && !bufFull_q;
    assign datain_ready = !bufFull_q && !rst;
    assign serout       = shreg_q[0];
    assign frame_start  = frameStart_q;
    assign idle_tx      = idleTx_q;

    // Next-state logic: buffer accept, word load / shift, and SYNC->RUN sequencing.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        buf_d        = buf_q;
        bufFull_d    = bufFull_q;
        syncCnt_d    = syncCnt_q;
        idleTx_d     = idleTx_q;
        frameStart_d = 1'b0;
`ifdef SER_COMMA_IDLE_EN
        toggle_d     = toggle_q;
`endif

        // A word accepted here is only visible to the next load edge, so a
        // transfer coinciding with a load edge waits for the following frame.
        if (xfer) begin
            buf_d     = datain;
            bufFull_d = 1'b1;
        end

        if (loadEdge) begin
            bitcnt_d     = 4'd0;
            frameStart_d = 1'b1;
            if ((state_q == RUN) && bufFull_q) begin
                shreg_d   = buf_q;
                bufFull_d = 1'b0;
                idleTx_d  = 1'b0;
            end else begin
                shreg_d  = idleWord;
                idleTx_d = 1'b1;
`ifdef SER_COMMA_IDLE_EN
                toggle_d = !toggle_q;
`endif
                if (state_q == SYNC) begin
                    syncCnt_d = syncCnt_q + 4'd1;
                    if (syncCnt_q == SYNC_LAST) begin
                        state_d = RUN;
                    end
                end
            end
        end else begin
            shreg_d  = {1'b0, shreg_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
        end
    end

    // State registers; bitcnt resets to 9 so the first edge after release loads a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            shreg_q      <= 10'd0;
            bitcnt_q     <= 4'd9;
            buf_q        <= 10'd0;
            bufFull_q    <= 1'b0;
            syncCnt_q    <= 4'd0;
            idleTx_q     <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            buf_q        <= buf_d;
            bufFull_q    <= bufFull_d;
            syncCnt_q    <= syncCnt_d;
            idleTx_q     <= idleTx_d;
            frameStart_q <= frameStart_d;
        end
    end

`ifdef SER_COMMA_IDLE_EN
    // Running-disparity toggle for the K28.5 idle; starts on the RD- form.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end
`endif

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// tb_lvds_tx_serializer: randomized source against a frame-level reference model.
// The model views the line as 10-cycle frames starting one edge after reset
// release; each frame carries either the oldest pending accepted word or an idle.
module tb_lvds_tx_serializer;

    localparam int SYNC_WORDS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] datain;
    logic       datain_valid;
    logic       datain_ready;
    logic       serout;
    logic       frame_start;
    logic       idle_tx;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    int         edgeNo;
    logic [9:0] pendQ[$];
    logic [9:0] curWord;
    logic       curIdle;
    int         idleCnt;

    // Source state
    logic [9:0] srcQ[$];
    logic       holding;
    int         validPct;
    logic       reached;

    lvds_tx_serializer #(.SYNC_WORDS(SYNC_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .datain       (datain),
        .datain_valid (datain_valid),
        .datain_ready (datain_ready),
        .serout       (serout),
        .frame_start  (frame_start),
        .idle_tx      (idle_tx)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    function automatic logic [9:0] idleWordOf(input int n);
`ifdef SER_COMMA_IDLE_EN
        return (n % 2 == 0) ? 10'h17C : 10'h283;
`else
        return 10'h2AA;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h edge=%0d time=%0t",
                     tag, obs, exp, edgeNo, $time);
        end
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check #1 later
    task automatic applyStimulus();
        logic v;
        logic rdyBefore;
        int   ph;
        @(negedge clk);
        if (!holding && srcQ.size() > 0 && $urandom_range(99) < validPct) holding = 1'b1;
        v            = holding;
        datain_valid = v;
        datain       = (srcQ.size() > 0) ? srcQ[0] : 10'($urandom);
        @(posedge clk);
        edgeNo++;
        rdyBefore = (pendQ.size() == 0);
        ph        = (edgeNo - 1) % 10;
        if (ph == 0) begin
            if ((edgeNo - 1) / 10 >= SYNC_WORDS && pendQ.size() > 0) begin
                curWord = pendQ.pop_front();
                curIdle = 1'b0;
            end else begin
                curWord = idleWordOf(idleCnt);
                idleCnt++;
                curIdle = 1'b1;
            end
        end
        if (v && rdyBefore) begin
            pendQ.push_back(srcQ.pop_front());
            holding = 1'b0;
        end
        #1;
        checkOutput("serout",      {9'd0, serout},       {9'd0, curWord[ph]});
        checkOutput("frame_start", {9'd0, frame_start},  {9'd0, (ph == 0)});
        checkOutput("idle_tx",     {9'd0, idle_tx},      {9'd0, curIdle});
        checkOutput("ready",       {9'd0, datain_ready}, {9'd0, (pendQ.size() == 0)});
    endtask

    // Asynchronous reset mid-cycle, immediate output checks, release mid-cycle
    task automatic doReset();
        #2;
        rst          = 1'b1;
        datain_valid = 1'b0;
        #1;
        checkOutput("rst_serout",      {9'd0, serout},       10'd0);
        checkOutput("rst_frame_start", {9'd0, frame_start},  10'd0);
        checkOutput("rst_idle_tx",     {9'd0, idle_tx},      10'd0);
        checkOutput("rst_ready",       {9'd0, datain_ready}, 10'd0);
        pendQ.delete();
        srcQ.delete();
        holding = 1'b0;
        edgeNo  = 0;
        curWord = 10'd0;
        curIdle = 1'b0;
        idleCnt = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rel_ready",  {9'd0, datain_ready}, 10'd1);
        checkOutput("rel_serout", {9'd0, serout},       10'd0);
    endtask

    initial begin
        rst          = 1'b1;
        datain_valid = 1'b0;
        datain       = 10'd0;
        holding      = 1'b0;
        validPct     = 100;
        reached      = 1'b0;
        doReset();

        // Word presented from release: waits through the SYNC idles
        srcQ.push_back(10'h3A5);
        repeat (60) applyStimulus();

        // Back-to-back words with valid held high
        srcQ.push_back(10'h001);
        srcQ.push_back(10'h3FE);
        srcQ.push_back(10'h155);
        repeat (40) applyStimulus();

        // Transfer landing exactly on a load edge
        for (int i = 0; i < 30 && !(edgeNo % 10 == 0 && pendQ.size() == 0); i++) applyStimulus();
        srcQ.push_back(10'($urandom));
        repeat (25) applyStimulus();

        // Randomized traffic with gaps
        validPct = 40;
        repeat (300) begin
            if (srcQ.size() < 3) srcQ.push_back(10'($urandom));
            applyStimulus();
        end

        // Reach bit 5 of a data frame with the buffer full, then reset there
        validPct = 100;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (srcQ.size() == 0) srcQ.push_back(10'($urandom));
            applyStimulus();
            if ((edgeNo - 1) % 10 == 5 && pendQ.size() > 0 && (edgeNo - 1) / 10 >= SYNC_WORDS)
                reached = 1'b1;
        end
        checkOutput("midword_reached", {9'd0, reached}, 10'd1);
        doReset();

        // Idle-only run after reset: old buffered word must never appear
        validPct = 0;
        repeat (60) applyStimulus();

        // More random traffic after the reset
        validPct = 60;
        repeat (200) begin
            if (srcQ.size() < 3) srcQ.push_back(10'($urandom));
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
